// File: rtl/fifo_cmd_pkg.sv
// ============================================================================
//  Module   : fifo_cmd_pkg
//  Purpose  : Shared command codes, default ack byte and decoder state
//             encoding for the FIFO byte-stream command decoder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_cmd_pkg;

    localparam logic [7:0] CMD_WRITE    = 8'h57;
    localparam logic [7:0] CMD_READ     = 8'h52;
    localparam logic [7:0] ACK_BYTE_DEF = 8'h06;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_ADDR_H = 4'd1,
        ST_ADDR_L = 4'd2,
        ST_LEN    = 4'd3,
        ST_WDATA  = 4'd4,
        ST_WBUS   = 4'd5,
        ST_RBUS   = 4'd6,
        ST_TX     = 4'd7,
        ST_ACK    = 4'd8
    } state_t;

endpackage : fifo_cmd_pkg

`default_nettype wire

// File: rtl/fifo_cmd_decoder.sv
// ============================================================================
//  Module   : fifo_cmd_decoder
//  Purpose  : Parses a host byte stream (CMD, ADDR_H, ADDR_L, LEN, payload)
//             into register-bus write/read bursts and returns read data or a
//             write ack as a byte stream.
//  Ports    : clk, rst (async, active low)
//             iRX_DATA/iRX_VALID/oRX_READY   - receive byte stream
//             oTX_DATA/oTX_VALID/iTX_READY   - transmit byte stream
//             oBUS_ADDR/oBUS_WR/oBUS_RD/oBUS_WDATA/iBUS_RDATA/iBUS_WAIT
//                                            - register bus
//             oERR_CNT                       - saturating protocol error count
//  Options  : FIFO_CMD_TIMEOUT_EN - inter-byte timeout that abandons a
//             partially received packet after TIMEOUT_CYCLES idle cycles.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_cmd_decoder
    import fifo_cmd_pkg::*;
#(
    parameter int          ADDR_W         = 16,
    parameter logic [7:0]  ACK_BYTE       = ACK_BYTE_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        iRX_DATA,
    input  logic              iRX_VALID,
    output logic              oRX_READY,
    output logic [7:0]        oTX_DATA,
    output logic              oTX_VALID,
    input  logic              iTX_READY,
    output logic [ADDR_W-1:0] oBUS_ADDR,
    output logic              oBUS_WR,
    output logic              oBUS_RD,
    output logic [7:0]        oBUS_WDATA,
    input  logic [7:0]        iBUS_RDATA,
    input  logic              iBUS_WAIT,
    output logic [7:0]        oERR_CNT
);

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [7:0]          r_addr_h, w_addr_h_nxt;
    logic [8:0]          r_cnt, w_cnt_nxt;
    logic [7:0]          r_wdata, w_wdata_nxt;
    logic [7:0]          r_txdata, w_txdata_nxt;
    logic                r_is_rd, w_is_rd_nxt;
    logic [7:0]          r_err;
    logic                w_err_inc;
    logic                w_rx_state;
    logic                w_rx_fire;

    // Receive side is open only while a packet header/payload is expected.
    // Gated with rst so every output reads 0 while reset is held.
    assign w_rx_state = (r_state == ST_IDLE)   || (r_state == ST_ADDR_H) ||
                        (r_state == ST_ADDR_L) || (r_state == ST_LEN)    ||
                        (r_state == ST_WDATA);
    assign oRX_READY  = w_rx_state & rst;
    assign w_rx_fire  = iRX_VALID & oRX_READY;

`ifdef FIFO_CMD_TIMEOUT_EN
    localparam logic [25:0] c_TMO_LAST = 26'(TIMEOUT_CYCLES - 1);
    logic [25:0] r_tmo;
    logic        w_tmo_state;
    logic        w_tmo_hit;

    // Only mid-packet receive states are timed; IDLE may wait forever.
    assign w_tmo_state = (r_state == ST_ADDR_H) || (r_state == ST_ADDR_L) ||
                         (r_state == ST_LEN)    || (r_state == ST_WDATA);
    assign w_tmo_hit   = w_tmo_state && !w_rx_fire && (r_tmo == c_TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_tmo <= '0;
        else if (!w_tmo_state || w_rx_fire)
            r_tmo <= '0;
        else
            r_tmo <= r_tmo + 26'd1;
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_addr_h_nxt = r_addr_h;
        w_cnt_nxt    = r_cnt;
        w_wdata_nxt  = r_wdata;
        w_txdata_nxt = r_txdata;
        w_is_rd_nxt  = r_is_rd;
        w_err_inc    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_rx_fire) begin
                    if (iRX_DATA == CMD_WRITE) begin
                        w_is_rd_nxt = 1'b0;
                        w_state_nxt = ST_ADDR_H;
                    end else if (iRX_DATA == CMD_READ) begin
                        w_is_rd_nxt = 1'b1;
                        w_state_nxt = ST_ADDR_H;
                    end else begin
                        w_err_inc = 1'b1;
                    end
                end
            end
            ST_ADDR_H: begin
                if (w_rx_fire) begin
                    w_addr_h_nxt = iRX_DATA;
                    w_state_nxt  = ST_ADDR_L;
                end
            end
            ST_ADDR_L: begin
                if (w_rx_fire) begin
                    // Header address is 16 bits; resize drops or pads to ADDR_W.
                    w_addr_nxt  = ADDR_W'({r_addr_h, iRX_DATA});
                    w_state_nxt = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_rx_fire) begin
                    // A length byte of zero encodes a full 256-byte burst.
                    w_cnt_nxt   = (iRX_DATA == 8'd0) ? 9'd256 : {1'b0, iRX_DATA};
                    w_state_nxt = r_is_rd ? ST_RBUS : ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (w_rx_fire) begin
                    w_wdata_nxt = iRX_DATA;
                    w_state_nxt = ST_WBUS;
                end
            end
            ST_WBUS: begin
                if (!iBUS_WAIT) begin
                    w_addr_nxt  = r_addr + ADDR_W'(1);
                    w_cnt_nxt   = r_cnt - 9'd1;
                    w_state_nxt = (r_cnt == 9'd1) ? ST_ACK : ST_WDATA;
                end
            end
            ST_RBUS: begin
                if (!iBUS_WAIT) begin
                    w_txdata_nxt = iBUS_RDATA;
                    w_addr_nxt   = r_addr + ADDR_W'(1);
                    w_state_nxt  = ST_TX;
                end
            end
            ST_TX: begin
                if (iTX_READY) begin
                    w_cnt_nxt   = r_cnt - 9'd1;
                    w_state_nxt = (r_cnt == 9'd1) ? ST_IDLE : ST_RBUS;
                end
            end
            ST_ACK: begin
                if (iTX_READY)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

`ifdef FIFO_CMD_TIMEOUT_EN
        // Abandon the packet; any bus writes already completed stand.
        if (w_tmo_hit) begin
            w_state_nxt = ST_IDLE;
            w_err_inc   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_addr_h <= '0;
            r_cnt    <= '0;
            r_wdata  <= '0;
            r_txdata <= '0;
            r_is_rd  <= 1'b0;
            r_err    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_addr_h <= w_addr_h_nxt;
            r_cnt    <= w_cnt_nxt;
            r_wdata  <= w_wdata_nxt;
            r_txdata <= w_txdata_nxt;
            r_is_rd  <= w_is_rd_nxt;
            if (w_err_inc && (r_err != 8'hFF))
                r_err <= r_err + 8'd1;
        end
    end

    assign oBUS_ADDR  = r_addr;
    assign oBUS_WDATA = r_wdata;
    assign oBUS_WR    = (r_state == ST_WBUS);
    assign oBUS_RD    = (r_state == ST_RBUS);
    assign oTX_VALID  = (r_state == ST_TX) || (r_state == ST_ACK);
    assign oTX_DATA   = (r_state == ST_ACK) ? ACK_BYTE : r_txdata;
    assign oERR_CNT   = r_err;

endmodule : fifo_cmd_decoder

`default_nettype wire

// File: tb/tb_fifo_cmd_decoder.sv
// ============================================================================
//  Module   : tb_fifo_cmd_decoder
//  Purpose  : Directed self-checking bench for fifo_cmd_decoder. A bus
//             responder and a TX sink run alongside a linear stimulus
//             sequence; expected values are hand-computed constants.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_cmd_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  iRX_DATA = 8'h00;
    logic        iRX_VALID = 1'b0;
    logic        oRX_READY;
    logic [7:0]  oTX_DATA;
    logic        oTX_VALID;
    logic        iTX_READY = 1'b0;
    logic [15:0] oBUS_ADDR;
    logic        oBUS_WR;
    logic        oBUS_RD;
    logic [7:0]  oBUS_WDATA;
    logic [7:0]  iBUS_RDATA = 8'h00;
    logic        iBUS_WAIT = 1'b0;
    logic [7:0]  oERR_CNT;

    int errors = 0;
    int checks = 0;

    fifo_cmd_decoder #(
        .ADDR_W         (16),
        .ACK_BYTE       (8'h06),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .iRX_DATA   (iRX_DATA),
        .iRX_VALID  (iRX_VALID),
        .oRX_READY  (oRX_READY),
        .oTX_DATA   (oTX_DATA),
        .oTX_VALID  (oTX_VALID),
        .iTX_READY  (iTX_READY),
        .oBUS_ADDR  (oBUS_ADDR),
        .oBUS_WR    (oBUS_WR),
        .oBUS_RD    (oBUS_RD),
        .oBUS_WDATA (oBUS_WDATA),
        .iBUS_RDATA (iBUS_RDATA),
        .iBUS_WAIT  (iBUS_WAIT),
        .oERR_CNT   (oERR_CNT)
    );

    always #5 clk = ~clk;

    // ---------------- bus responder ----------------
    int          bus_wait_n = 0;
    int          bus_wait_ctr = 0;
    int          rd_hold = 0;
    int          both_hi = 0;
    logic [7:0]  rd_mem [0:255];
    logic [15:0] wr_addr_q [$];
    logic [7:0]  wr_data_q [$];
    logic [15:0] rd_addr_q [$];

    always @(negedge clk) begin
        if (oBUS_WR && oBUS_RD) both_hi++;
        if (oBUS_WR || oBUS_RD) begin
            if (bus_wait_ctr < bus_wait_n) begin
                iBUS_WAIT = 1'b1;
                bus_wait_ctr++;
                if (oBUS_RD) rd_hold++;
            end else begin
                iBUS_WAIT    = 1'b0;
                bus_wait_ctr = 0;
                iBUS_RDATA   = rd_mem[oBUS_ADDR[7:0]];
                if (oBUS_WR) begin
                    wr_addr_q.push_back(oBUS_ADDR);
                    wr_data_q.push_back(oBUS_WDATA);
                end else begin
                    rd_addr_q.push_back(oBUS_ADDR);
                end
            end
        end else begin
            iBUS_WAIT    = 1'b0;
            bus_wait_ctr = 0;
        end
    end

    // ---------------- TX sink ----------------
    int         stall_len = 0;
    int         stall_done = 0;
    int         stall_viol = 0;
    logic       stall_have = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic [7:0] tx_q [$];

    always @(negedge clk) begin
        if (oTX_VALID) begin
            if (stall_done < stall_len) begin
                iTX_READY = 1'b0;
                stall_done++;
                if (stall_have && (oTX_DATA !== stall_data)) stall_viol++;
                if (oRX_READY || oBUS_RD) stall_viol++;
                stall_data = oTX_DATA;
                stall_have = 1'b1;
            end else begin
                iTX_READY  = 1'b1;
                stall_have = 1'b0;
                tx_q.push_back(oTX_DATA);
            end
        end else begin
            iTX_READY  = 1'b0;
            stall_have = 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        iRX_DATA  = b;
        iRX_VALID = 1'b1;
        while (!oRX_READY && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("rx_accept_timeout", n, 0);
        @(posedge clk);
        #1 iRX_VALID = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_tx(input int n);
        int c = 0;
        while (tx_q.size() < n && c < 5000) begin
            @(negedge clk);
            c++;
        end
        chk("tx_wait_bound", (tx_q.size() >= n) ? 1 : 0, 1);
        repeat (4) @(negedge clk);
    endtask

    int txb, wrb, rdb, bad;

    initial begin
        for (int i = 0; i < 256; i++) rd_mem[i] = 8'h00;
        rd_mem[8'h20] = 8'h11; rd_mem[8'h21] = 8'h22; rd_mem[8'h22] = 8'h33;
        rd_mem[8'h30] = 8'h5A;
        rd_mem[8'h40] = 8'hA1; rd_mem[8'h41] = 8'hB2;
        rd_mem[8'h00] = 8'hC7;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", oRX_READY, 0);
        chk("rst_tx_valid", oTX_VALID, 0);
        chk("rst_strobes", {oBUS_WR, oBUS_RD}, 0);
        chk("rst_addr_data", {oBUS_ADDR, oBUS_WDATA, oTX_DATA}, 0);
        chk("rst_err", oERR_CNT, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_rx_ready", oRX_READY, 1);

        // Write burst of two
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'hAA); send_byte(8'hBB);
        wait_tx(1);
        chk("wr_count", wr_addr_q.size(), 2);
        chk("wr0", {wr_addr_q[0], wr_data_q[0]}, 24'h0010AA);
        chk("wr1", {wr_addr_q[1], wr_data_q[1]}, 24'h0011BB);
        chk("wr_ack", tx_q[0], 8'h06);
        chk("wr_err", oERR_CNT, 0);

        // Read burst with 3 wait cycles per access
        txb = tx_q.size(); rdb = rd_addr_q.size();
        bus_wait_n = 3;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h20); send_byte(8'h03);
        wait_tx(txb + 3);
        chk("rd_tx0", tx_q[txb], 8'h11);
        chk("rd_tx1", tx_q[txb+1], 8'h22);
        chk("rd_tx2", tx_q[txb+2], 8'h33);
        chk("rd_addrs", {rd_addr_q[rdb], rd_addr_q[rdb+1], rd_addr_q[rdb+2]}, 48'h002000210022);
        chk("rd_hold_cycles", rd_hold, 9);
        chk("rd_no_writes", wr_addr_q.size(), 2);
        bus_wait_n = 0;

        // LEN=0 burst of 256 with address wrap
        txb = tx_q.size(); wrb = wr_addr_q.size();
        send_byte(8'h57); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h00);
        for (int i = 0; i < 256; i++) send_byte(8'(i));
        wait_tx(txb + 1);
        repeat (20) @(negedge clk);
        chk("wrap_count", wr_addr_q.size() - wrb, 256);
        chk("wrap_first", {wr_addr_q[wrb], wr_data_q[wrb]}, 24'hFFFF00);
        chk("wrap_second", {wr_addr_q[wrb+1], wr_data_q[wrb+1]}, 24'h000001);
        chk("wrap_last", {wr_addr_q[wrb+255], wr_data_q[wrb+255]}, 24'h00FEFF);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (wr_addr_q[wrb+i] !== 16'(16'hFFFF + i) || wr_data_q[wrb+i] !== 8'(i)) bad++;
        chk("wrap_all", bad, 0);
        chk("wrap_one_ack", tx_q.size() - txb, 1);
        chk("wrap_ack_byte", tx_q[txb], 8'h06);

        // Bad commands saturate the error counter
        txb = tx_q.size(); wrb = wr_addr_q.size(); rdb = rd_addr_q.size();
        for (int i = 0; i < 300; i++) send_byte(8'h00);
        repeat (3) @(negedge clk);
        chk("sat_err", oERR_CNT, 255);
        chk("sat_no_resp", tx_q.size() - txb, 0);
        chk("sat_no_bus", (wr_addr_q.size() - wrb) + (rd_addr_q.size() - rdb), 0);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h30); send_byte(8'h01);
        wait_tx(txb + 1);
        chk("sat_read_data", tx_q[txb], 8'h5A);
        chk("sat_read_addr", rd_addr_q[rdb], 16'h0030);
        chk("sat_err_hold", oERR_CNT, 255);

        // TX backpressure on the first byte of a 2-byte read
        txb = tx_q.size(); rdb = rd_addr_q.size();
        stall_len = stall_done + 10;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h40); send_byte(8'h02);
        wait_tx(txb + 2);
        chk("bp_stall_cycles", stall_done, 10);
        chk("bp_violations", stall_viol, 0);
        chk("bp_data", {tx_q[txb], tx_q[txb+1]}, 16'hA1B2);
        chk("bp_reads", rd_addr_q.size() - rdb, 2);
        chk("never_both_strobes", both_hi, 0);

        // Reset in the middle of a write burst
        txb = tx_q.size();
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h50); send_byte(8'h03);
        send_byte(8'hAA);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_outputs", {oBUS_WR, oBUS_RD, oTX_VALID, oRX_READY}, 0);
        chk("mid_rst_err", oERR_CNT, 0);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("mid_rst_no_ack", tx_q.size() - txb, 0);
        chk("mid_rst_idle", oRX_READY, 1);

`ifdef FIFO_CMD_TIMEOUT_EN
        // Stalled header times out; next packet decodes normally
        txb = tx_q.size(); rdb = rd_addr_q.size();
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
        repeat (110) @(negedge clk);
        chk("tmo_err", oERR_CNT, 1);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        wait_tx(txb + 1);
        chk("tmo_read_count", rd_addr_q.size() - rdb, 1);
        chk("tmo_tx", {tx_q.size() - txb, 24'(tx_q[txb])}, {32'd1, 24'h0000C7});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fifo_cmd_decoder

`default_nettype wire

// File: doc/fifo_cmd_decoder.md
Name: fifo_cmd_decoder

Overview:
- Sits directly downstream of the FTDI FIFO receive path and upstream of its transmit path.
- Parses the host byte stream into register-bus transactions: write bursts and read bursts.
- Returns read data and write acks as a byte stream to the FIFO transmit side.
- Replaces ad-hoc PIO decoding; the LED/7SEG registers hang off the bus side.

Parameters:
- ADDR_W, 16, register-bus address width; bytes 1-2 of the header carry the address, and bits above ADDR_W are dropped.
- ACK_BYTE, 8'h06, byte returned after a completed write burst.
- TIMEOUT_CYCLES, 50_000_000, inter-byte timeout in clk cycles. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- iRX_DATA  in  8  byte from FIFO receive side
- iRX_VALID  in  1  iRX_DATA valid
- oRX_READY  out  1  decoder accepts byte; transfer occurs when iRX_VALID && oRX_READY
- oTX_DATA  out  8  byte to FIFO transmit side
- oTX_VALID  out  1  oTX_DATA valid
- iTX_READY  in  1  FIFO transmit side accepts byte
- oBUS_ADDR  out  ADDR_W  register address
- oBUS_WR  out  1  write strobe, held until accepted
- oBUS_RD  out  1  read strobe, held until accepted
- oBUS_WDATA  out  8  write data
- iBUS_RDATA  in  8  read data, valid in the accept cycle
- iBUS_WAIT  in  1  wait request; a strobe is accepted on the cycle iBUS_WAIT==0
- oERR_CNT  out  8  saturating count of protocol errors

Behaviour:
- Reset (rst==0, asynchronous): state=IDLE; all outputs 0.
- Packet format: CMD, ADDR_H, ADDR_L, LEN, then LEN payload bytes (write only).
  - CMD 8'h57 = write; CMD 8'h52 = read.
  - LEN==0 means 256 bytes. The internal count is 9 bits.
- Any other CMD byte: consumed, oERR_CNT+1 (saturates at 255), stay IDLE. No response.
- States: IDLE, ADDR_H, ADDR_L, LEN, WDATA, WBUS, RBUS, TX, ACK.
- oRX_READY=1 only in IDLE, ADDR_H, ADDR_L, LEN, WDATA. Each accepted byte advances the state by one.
- Write path:
  - WDATA latches the byte into oBUS_WDATA, then goes to WBUS.
  - WBUS asserts oBUS_WR. On the accept cycle: deassert, address+1 (wraps modulo 2^ADDR_W), count-1.
  - If count reaches 0 go to ACK, else return to WDATA.
  - ACK drives oTX_DATA=ACK_BYTE with oTX_VALID=1 until iTX_READY, then IDLE.
- Read path:
  - After LEN go to RBUS. RBUS asserts oBUS_RD.
  - On the accept cycle: latch iBUS_RDATA into oTX_DATA, address+1, go to TX.
  - TX holds oTX_VALID until iTX_READY, then count-1. Go to RBUS, or IDLE when count reaches 0.
- Ordering and latency:
  - At most one bus transaction is outstanding; oBUS_WR and oBUS_RD are never high together.
  - Minimum latency from bus accept to oTX_VALID is 1 cycle.
- Backpressure: iTX_READY low stalls TX/ACK indefinitely. No RX bytes are accepted during a read burst or a pending ack.
- Reset mid-burst aborts the burst immediately; no partial ack is sent.
- Address wrap: 16'hFFFF+1 -> 16'h0000 within a burst.

Optional Feature:
- Macro: FIFO_CMD_TIMEOUT_EN.
- When defined:
  - A 26-bit counter clears on every accepted RX byte and counts in ADDR_H, ADDR_L, LEN and WDATA only.
  - On reaching TIMEOUT_CYCLES: go to IDLE, oERR_CNT+1, no ack. Bus writes already issued remain.
- When undefined: no counter is present, and the decoder waits forever mid-packet.

Decomposition:
- Shared package fifo_cmd_pkg: CMD_WRITE=8'h57, CMD_READ=8'h52, the state enum, and the default ACK_BYTE.
- No sub-module is needed. The timeout counter stays inline under the macro.
- Sits between Android2FPGAMemoryMap_FIFO byte streams and the register file.

Test Plan:
- Write burst: RX 57 00 10 02 AA BB -> bus writes (0x0010,AA), (0x0011,BB); then TX 06; oERR_CNT=0.
- Read burst with bus stall: RX 52 00 20 03, iBUS_WAIT=1 for 3 cycles on each access, bus returns 11,22,33 -> TX 11,22,33 in order; oBUS_RD held during each wait.
- LEN=0 and wrap: RX 57 FF FF 00 + 256 bytes -> 256 writes at 0xFFFF,0x0000..0x00FE; exactly one 06.
- Bad command and saturation: RX 300 bytes of 8'h00 -> oERR_CNT=255; then a valid read still works.
- TX backpressure: read LEN=2 with iTX_READY low for 10 cycles -> oTX_VALID held, data stable, oRX_READY=0, no second bus read until the first byte is sent.
- (FIFO_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=100) RX 57 00 00, then idle 100 cycles -> IDLE, oERR_CNT=1; next 52 00 00 01 -> one read and one TX byte.
